if_stage_fetch: RTL
===================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the decode stage and consumes `hazard_detected` from the hazard detection unit.
- Holds the PC and drives a variable-latency instruction-memory request/ready handshake.
- Stalls on a load-use/data hazard or a global memory freeze; redirects and flushes on a taken branch from EXE.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; instruction width is fixed at 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_detected  in  1  stall request from the hazard detection unit.
- freeze  in  1  global pipeline freeze (data-memory wait).
- branch_taken  in  1  taken branch resolved in EXE.
- branch_addr  in  ADDR_W  branch target.
- imem_req  out  1  instruction read request.
- imem_addr  out  ADDR_W  instruction read address.
- imem_ready  in  1  imem_rdata valid; completes the request this cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- if_id_pc  out  ADDR_W  PC+4 of the held instruction.
- if_id_instr  out  32  held instruction.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC, state = FETCH.
  - if_id_valid = 0, if_id_pc = 0, if_id_instr = 0.
  - Skid register is cleared.
  - imem_req = 0 while rst is high.
- Define stall = hazard_detected | freeze.
- Define redirect = branch_taken & ~freeze.
  - When freeze is high, branch_taken is ignored; EXE is frozen and re-presents it.
- imem_addr = pc in FETCH and HOLD; imem_addr = the latched drain address in DRAIN.
- The address must stay stable while imem_req=1 until imem_ready.
- imem_ready with imem_req=0 is ignored.
- FETCH state: imem_req = 1.
  - redirect & imem_ready: drop the response; pc <= branch_addr; stay in FETCH.
  - redirect & ~imem_ready: latch the drain address = pc; pc <= branch_addr; go to DRAIN.
  - ~redirect & imem_ready & ~stall: IF/ID <= {1, pc+4, imem_rdata}; pc <= pc+4.
  - ~redirect & imem_ready & stall: skid <= {pc+4, imem_rdata}; pc <= pc+4; go to HOLD; IF/ID unchanged.
  - ~redirect & ~imem_ready & ~stall: if_id_valid <= 0 (bubble); pc, if_id_pc and if_id_instr are unchanged.
  - ~redirect & ~imem_ready & stall: IF/ID unchanged.
- HOLD state: imem_req = 0.
  - redirect: discard skid; go to FETCH.
  - ~stall: IF/ID <= {1, skid}; go to FETCH.
  - stall: remain in HOLD.
- DRAIN state: imem_req = 1 at the old address.
  - imem_ready: discard data; go to FETCH with the new pc.
  - A further redirect while in DRAIN updates pc only.
- Flush: any redirect sets if_id_valid <= 0 in that same edge, overriding hazard_detected.
- Latency:
  - Single-cycle memory with no stall: one instruction per cycle.
  - Instruction appears on IF/ID one edge after imem_ready.
- PC arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Bubbles are not forced on stall; the held IF/ID contents are re-presented.
- if_id_pc and if_id_instr are don't-care when if_id_valid = 0. The bench checks only valid entries.
- Reset mid-operation (any state, including DRAIN):
  - Returns to the reset values immediately.
  - An outstanding memory response is abandoned.
  - The memory model must accept re-request after reset.

Test Plan:
1. Reset with RESET_PC=0 and imem_ready tied high, 4 cycles -> IF/ID shows pc 4, 8, 12, 16 with instructions mem[0], mem[4], mem[8], mem[12]; valid=1 from the first edge after reset release.
2. hazard_detected high for 2 cycles while IF/ID holds pc=8 and ready=1 -> IF/ID holds pc=8 for both cycles; skid holds pc=12; no request in HOLD; pc=12 loads on the first edge after the stall drops; no instruction lost or duplicated.
3. branch_taken with branch_addr=0x40 while ready=1 and hazard_detected=1 -> next edge valid=0; the following fetch addresses 0x40; IF/ID then shows pc 0x44.
4. Memory with 3-cycle latency; branch to 0x80 on the 2nd wait cycle -> imem_addr stays at the old pc until ready; that data is dropped; the next request is at 0x80; only 0x80's instruction reaches IF/ID (pc 0x84).
5. freeze=1 together with branch_taken=1 -> the branch is ignored and IF/ID holds; release freeze with branch_taken still high -> the flush and redirect occur then.
6. rst asserted asynchronously in HOLD, and again in DRAIN -> outputs go to zero immediately without a clock; the first request after release is at RESET_PC; RESET_PC=0xFFFF_FFFC also checks wrap to pc+4 = 0.

Source files
------------

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, talks to a variable-latency instruction memory through a
// request/ready handshake, stalls on hazards or freeze, and redirects and
// flushes on a taken branch from EXE.
//
// Handshake: imem_req high means imem_addr is a live read address. The
// address is held stable until the cycle in which imem_ready is seen high.
// That cycle completes the read, and imem_rdata is valid in it. imem_ready
// is ignored while imem_req is low.
module if_stage_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard_detected,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic [1:0]        dbg_state
);

  // FETCH: request at pc. HOLD: response parked in skid while stalled.
  // DRAIN: a redirect left a request in flight; finish it and drop the data.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drain_addr;
  logic [ADDR_W-1:0] r_skid_pc;
  logic [31:0]       r_skid_instr;
  logic              r_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [31:0]       r_if_instr;

  state_t            w_state_n;
  logic [ADDR_W-1:0] w_pc_n;
  logic [ADDR_W-1:0] w_drain_n;
  logic [ADDR_W-1:0] w_skid_pc_n;
  logic [31:0]       w_skid_instr_n;
  logic              w_valid_n;
  logic [ADDR_W-1:0] w_if_pc_n;
  logic [31:0]       w_if_instr_n;

  logic              w_stall;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_pc_plus4;

  // A frozen EXE re-presents its branch later, so freeze masks it.
  assign w_stall    = hazard_detected | freeze;
  assign w_redirect = branch_taken & ~freeze;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  assign imem_req    = ~rst & (r_state != S_HOLD);
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign if_id_valid = r_valid;
  assign if_id_pc    = r_if_pc;
  assign if_id_instr = r_if_instr;
  assign dbg_state   = r_state;

  // Next-state, PC, skid and IF/ID update rules.
  always_comb begin
    w_state_n      = r_state;
    w_pc_n         = r_pc;
    w_drain_n      = r_drain_addr;
    w_skid_pc_n    = r_skid_pc;
    w_skid_instr_n = r_skid_instr;
    w_valid_n      = r_valid;
    w_if_pc_n      = r_if_pc;
    w_if_instr_n   = r_if_instr;
    case (r_state)
      S_FETCH: begin
        if (w_redirect) begin
          w_valid_n = 1'b0;
          w_pc_n    = branch_addr;
          if (!imem_ready) begin
            w_drain_n = r_pc;
            w_state_n = S_DRAIN;
          end
        end else if (imem_ready) begin
          w_pc_n = w_pc_plus4;
          if (w_stall) begin
            w_skid_pc_n    = w_pc_plus4;
            w_skid_instr_n = imem_rdata;
            w_state_n      = S_HOLD;
          end else begin
            w_valid_n    = 1'b1;
            w_if_pc_n    = w_pc_plus4;
            w_if_instr_n = imem_rdata;
          end
        end else if (!w_stall) begin
          w_valid_n = 1'b0;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_valid_n = 1'b0;
          w_pc_n    = branch_addr;
          w_state_n = S_FETCH;
        end else if (!w_stall) begin
          w_valid_n    = 1'b1;
          w_if_pc_n    = r_skid_pc;
          w_if_instr_n = r_skid_instr;
          w_state_n    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_redirect) begin
          w_valid_n = 1'b0;
          w_pc_n    = branch_addr;
        end
        if (imem_ready) begin
          w_state_n = S_FETCH;
        end
      end
      default: begin
        w_state_n = S_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_valid      <= 1'b0;
      r_if_pc      <= '0;
      r_if_instr   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pc         <= w_pc_n;
      r_drain_addr <= w_drain_n;
      r_skid_pc    <= w_skid_pc_n;
      r_skid_instr <= w_skid_instr_n;
      r_valid      <= w_valid_n;
      r_if_pc      <= w_if_pc_n;
      r_if_instr   <= w_if_instr_n;
    end
  end

endmodule
